// File: rtl/sram_sample_reader.sv
// sram_sample_reader: streams a run of words out of the two 512x32 sample
// SRAM banks over a 32-bit valid/ready interface. Reads go out on the SRAM
// read-only port, the one-cycle macro latency is absorbed by a small FIFO,
// and read issue is throttled so that FIFO can never overflow.
//
// Stream handshake: m_valid_o means m_data_o holds the FIFO head; a word
// moves on any rising edge where m_valid_o and m_ready_i are both high.
// While m_valid_o is high and m_ready_i is low, m_data_o does not change.
module sram_sample_reader #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [9:0]  start_addr_i,
    input  logic [10:0] length_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [10:0] xfer_count_o,
    output logic [1:0]  mem_renb_o,
    output logic [8:0]  mem_raddr_o,
    input  logic [31:0] mem0_data_i,
    input  logic [31:0] mem1_data_i,
    output logic [31:0] m_data_o,
    output logic        m_valid_o,
    input  logic        m_ready_i
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW:0] LIMIT = (CW + 1)'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    // FSM state is kept as a named enum so checkers can bind to it directly.
    state_t state;

    logic [9:0]  addr;
    logic [10:0] remaining;
    logic        rd_pend;
    logic        rd_bank;

    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          push;
    logic          pop;
    logic          rd_now;
    logic          space_ok;
    logic [31:0]   push_data;
    logic [CW-1:0] count_n;
    logic [AW-1:0] rd_ptr_n;
    logic [31:0]   head_n;
    logic [10:0]   len_clamped;

    // Next-state FIFO bookkeeping and the read throttle.
    always_comb begin
        push        = rd_pend;
        push_data   = rd_bank ? mem1_data_i : mem0_data_i;
        pop         = m_valid_o & m_ready_i;
        rd_now      = (mem_renb_o != 2'b11);
        count_n     = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        rd_ptr_n    = pop ? rd_ptr + AW'(1) : rd_ptr;
        // When the FIFO drains to just the word being pushed, that word is
        // the new head and has not reached the array yet.
        head_n      = (push && (count == {{AW{1'b0}}, pop})) ? push_data : fifo_mem[rd_ptr_n];
        // A new read is allowed if, after this edge, stored words plus the
        // read still in the SRAM leave room for it.
        space_ok    = ({1'b0, count_n} + {{CW{1'b0}}, rd_now}) <= LIMIT;
        len_clamped = (length_i > 11'd1024) ? 11'd1024 : length_i;
    end

    // FIFO storage; stale entries past the pointers are never observed.
    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_data;
        end
    end

    // Return-path tag pipe, FIFO pointers and registered stream outputs.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || abort_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            m_valid_o <= 1'b0;
            rd_pend   <= 1'b0;
            rd_bank   <= 1'b0;
            if (wb_rst_i) begin
                m_data_o <= 32'd0;
            end
        end else begin
            rd_pend   <= rd_now;
            rd_bank   <= ~mem_renb_o[1];
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr    <= rd_ptr_n;
            count     <= count_n;
            m_valid_o <= (count_n != '0);
            if (count_n != '0) begin
                m_data_o <= head_n;
            end
        end
    end

    // Transfer FSM: read issue, word counting and status outputs.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state        <= IDLE;
            addr         <= 10'd0;
            remaining    <= 11'd0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            xfer_count_o <= 11'd0;
            mem_renb_o   <= 2'b11;
            mem_raddr_o  <= 9'd0;
        end else if (abort_i) begin
            state      <= IDLE;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            mem_renb_o <= 2'b11;
        end else begin
            done_o     <= 1'b0;
            mem_renb_o <= 2'b11;
            if (pop) begin
                xfer_count_o <= xfer_count_o + 11'd1;
            end
            case (state)
                IDLE: begin
                    if (start_i) begin
                        xfer_count_o <= 11'd0;
                        busy_o       <= 1'b1;
                        if (len_clamped == 11'd0) begin
                            // Nothing to read: drain check passes at once.
                            state <= FLUSH;
                        end else begin
                            // First read goes out on the start edge itself.
                            state       <= READ;
                            mem_renb_o  <= start_addr_i[9] ? 2'b01 : 2'b10;
                            mem_raddr_o <= start_addr_i[8:0];
                            addr        <= start_addr_i + 10'd1;
                            remaining   <= len_clamped - 11'd1;
                        end
                    end
                end
                READ: begin
                    if (remaining == 11'd0) begin
                        state <= FLUSH;
                    end else if (space_ok) begin
                        mem_renb_o  <= addr[9] ? 2'b01 : 2'b10;
                        mem_raddr_o <= addr[8:0];
                        addr        <= addr + 10'd1;
                        remaining   <= remaining - 11'd1;
                    end
                end
                FLUSH: begin
                    if ((count == '0) && !rd_pend && !rd_now) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
